// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 5..9 data bits, 1 or 2 stop bits.
// Parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                        CLK100MHZ,
  input  logic                        reset_n,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        TXD,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = 4;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_fd
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_po
    $error("PARITY_ODD must be 0 or 1");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t state_q, state_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;

  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic push, pop, bit_end, last_stop;

  assign in_ready   = fifo_count < (AW+1)'(FIFO_DEPTH);
  assign push       = in_valid && in_ready;
  assign bit_end    = baud_q == CW'(CLKS_PER_BIT-1);
  assign last_stop  = (state_q == STOP) && bit_end &&
                      (bit_q == BW'(STOP_BITS-1));
  assign pop        = (fifo_count != '0) &&
                      ((state_q == IDLE) || last_stop);
  assign frame_done = last_stop;
  assign busy       = state_q != IDLE;
  assign TXD        = txd_q;

  always_ff @(posedge CLK100MHZ) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // A pop always starts a fresh frame, whether from IDLE or the final stop cycle
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (pop) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = '0;
      shreg_d = mem[rd_ptr];
      txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = (^mem[rd_ptr]) ^ (PARITY_ODD != 0);
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          baud_d = '0;
          txd_d  = 1'b1;
        end
        START: if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
        DATA: if (bit_end) begin
          if (bit_q == BW'(DATA_BITS-1)) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = par_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
`endif
        STOP: if (bit_end) begin
          if (bit_q == BW'(STOP_BITS-1)) begin
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo, CLKS_PER_BIT=4.
// Instance u0 has 1 stop bit / even parity, u1 has 2 stop bits / odd parity.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] d0, d1;
  logic       v0, v1;
  logic       rdy0, rdy1;
  logic       txd0, txd1;
  logic       busy0, busy1;
  logic       done0, done1;
  logic [2:0] cnt0, cnt1;
  logic       sel;

  int nvec;
  int nerr;

  wire       txd_m  = sel ? txd1  : txd0;
  wire       rdy_m  = sel ? rdy1  : rdy0;
  wire       busy_m = sel ? busy1 : busy0;
  wire       done_m = sel ? done1 : done0;
  wire [2:0] cnt_m  = sel ? cnt1  : cnt0;

  uart_tx_fifo #(
    .DATA_BITS(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4),
    .STOP_BITS(1), .PARITY_ODD(0)
  ) u0 (
    .CLK100MHZ(clk), .reset_n(rst_n),
    .in_data(d0), .in_valid(v0), .in_ready(rdy0),
    .TXD(txd0), .busy(busy0), .frame_done(done0),
    .fifo_count(cnt0)
  );

  uart_tx_fifo #(
    .DATA_BITS(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4),
    .STOP_BITS(2), .PARITY_ODD(1)
  ) u1 (
    .CLK100MHZ(clk), .reset_n(rst_n),
    .in_data(d1), .in_valid(v1), .in_ready(rdy1),
    .TXD(txd1), .busy(busy1), .frame_done(done1),
    .fifo_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [7:0]  data;
    logic [10:0] frm;
    logic        par;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] w3[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    @(negedge clk);
    if (sel) begin d1 = d; v1 = 1'b1; end
    else     begin d0 = d; v0 = 1'b1; end
    n = 0;
    while (!rdy_m && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", rdy_m, 1);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  function automatic logic fbit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (P == 1 && k == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic run_vec(input int i, input vec_t v);
    int nb, done_at, pulses, glitch;
    logic [11:0] exp, got;
    logic cur;
    bit found;
    nb  = 10 + P + int'(v.sel);
    exp = '1;
    for (int k = 0; k < 9; k++) exp[k] = v.frm[k];
    if (P == 1) exp[9] = v.par;
    sel = v.sel;
    push(v.data);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (!txd_m) found = 1;
      else @(negedge clk);
    end
    chk($sformatf("v%0d_start", i), found, 1);
    got = '1; done_at = -1; pulses = 0; glitch = 0; cur = 1'b1;
    for (int c = 0; c < nb*4; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 4 == 0) cur = txd_m;
      else if (txd_m !== cur) glitch++;
      if (c % 4 == 1) got[c/4] = txd_m;
      if (c < nb*4 - 1) chk($sformatf("v%0d_busy", i), busy_m, 1);
      if (done_m) begin pulses++; done_at = c; end
    end
    @(negedge clk);
    if (done_m) pulses++;
    chk($sformatf("v%0d_bits", i), got, exp);
    chk($sformatf("v%0d_glitch", i), glitch, 0);
    chk($sformatf("v%0d_done_at", i), done_at, nb*4 - 1);
    chk($sformatf("v%0d_pulses", i), pulses, 1);
    chk($sformatf("v%0d_idle_busy", i), busy_m, 0);
    chk($sformatf("v%0d_idle_txd", i), txd_m, 1);
    chk($sformatf("v%0d_count", i), cnt_m, 0);
  endtask

  task automatic test_b2b();
    int idx, frames, low_at, t0, gaps, bad, nb0;
    bit take, seen;
    logic q[$];
    sel = 0; idx = 0; frames = 0; low_at = -1;
    t0 = -1; gaps = 0; seen = 0; nb0 = 10 + P;
    @(negedge clk);
    d0 = w3[0];
    v0 = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (busy0) seen = 1;
      else if (seen && frames < 6) gaps++;
      if (done0) frames++;
      if (!rdy0 && low_at < 0) low_at = idx;
      if (t0 < 0 && !txd0) t0 = c;
      if (t0 >= 0 && (c - t0) % 4 == 1) q.push_back(txd0);
      if (idx == 6 && seen && !busy0) break;
      take = v0 && rdy0;
      @(posedge clk);
      #1;
      if (take) begin
        idx++;
        if (idx == 6) v0 = 1'b0;
        else d0 = w3[idx];
      end
      @(negedge clk);
    end
    v0 = 1'b0;
    bad = 0;
    for (int f = 0; f < 6; f++)
      for (int k = 0; k < nb0; k++)
        if (f*nb0 + k >= q.size() || q[f*nb0 + k] !== fbit(w3[f], k))
          bad++;
    chk("b2b_low_at", low_at, 5);
    chk("b2b_accepted", idx, 6);
    chk("b2b_frames", frames, 6);
    chk("b2b_gaps", gaps, 0);
    chk("b2b_stream", bad, 0);
    chk("b2b_busy_end", busy0, 0);
    chk("b2b_count", cnt0, 0);
  endtask

  task automatic test_reset();
    bit found;
    sel = 0;
    push(8'h37);
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (!txd0) found = 1;
      else @(negedge clk);
    end
    chk("rst_start", found, 1);
    push(8'hC3);
    repeat (15) @(negedge clk);
    chk("rst_pre_txd", txd0, 0);
    chk("rst_pre_count", cnt0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_txd", txd0, 1);
    chk("rst_count", cnt0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ready", rdy0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_quiet_txd", txd0, 1);
    chk("rst_quiet_busy", busy0, 0);
    run_vec(9, tbl[0]);
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst_n = 1'b0; sel = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;

    tbl[0] = '{1'b0, 8'hA1, 11'b11_10100001_0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 11'b11_00000000_0, 1'b0};
    tbl[2] = '{1'b0, 8'hFF, 11'b11_11111111_0, 1'b0};
    tbl[3] = '{1'b0, 8'h80, 11'b11_10000000_0, 1'b1};
    tbl[4] = '{1'b1, 8'h55, 11'b11_01010101_0, 1'b1};
    tbl[5] = '{1'b1, 8'h07, 11'b11_00000111_0, 1'b0};
    w3 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};

    repeat (2) @(negedge clk);
    chk("reset_txd", txd0, 1);
    chk("reset_ready", rdy0, 1);
    chk("reset_busy", busy0, 0);
    chk("reset_count", cnt0, 0);
    chk("reset_done", done0, 0);
    chk("reset_txd_u1", txd1, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

    test_b2b();
    repeat (2) @(negedge clk);
    test_reset();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
